spi_pe_frame_ctrl: RTL and testbench
====================================

Name: spi_pe_frame_ctrl

Overview:
- Frame-level sequencer that sits beside the byte-level SPI peripheral (spi_pe) on the FPGA side of the election SPI link.
- Accepts one wide TX frame from upstream and feeds it to the peripheral byte by byte, MSB byte first, timed to peripheral byte completions.
- Assembles received peripheral bytes into one wide RX frame.
- Tracks chip select, flags frames truncated by early CS deassertion, and zero-fills MISO when no TX frame is loaded.

Parameters:
- DATA_WIDTH, 8, bits per SPI byte; must match the peripheral's DATA_WIDTH.
- FRAME_WORDS, 4, bytes per frame (≥2).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  reset
- tx_data_in  input  DATA_WIDTH*FRAME_WORDS  frame to send on CIPO
- tx_valid_in  input  1  tx_data_in valid
- tx_ready_out  output  1  frame accepted when tx_valid_in && tx_ready_out
- byte_out  output  DATA_WIDTH  to peripheral data_in
- byte_valid_out  output  1  to peripheral valid_in; one-cycle pulse
- byte_in  input  DATA_WIDTH  from peripheral data_out
- byte_valid_in  input  1  from peripheral data_valid_out
- chip_sel_in  input  1  raw CS from pin, active low, asynchronous
- rx_data_out  output  DATA_WIDTH*FRAME_WORDS  assembled frame; first byte received in MSBs
- rx_valid_out  output  1  one-cycle pulse, rx_data_out valid
- frame_error_out  output  1  one-cycle pulse on truncated frame
- busy_out  output  1  high in any state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high (clk_in, rst_in).
- Reset values:
  - state = IDLE; byte_out = 0; byte_valid_out, rx_valid_out, frame_error_out = 0; rx_data_out = 0.
  - tx_ready_out = 0 while rst_in is high; byte index = 0.
- CS synchronisation:
  - chip_sel_in passes through a 2-flop synchroniser; cs_low = !synced value.
  - Timing requirement: DCLK half-period ≥ 8 clk_in cycles.
- tx_ready_out (combinational) = (state==IDLE) && !cs_low && !rst_in.
- Byte k of the TX frame is tx_frame[DATA_WIDTH*(FRAME_WORDS-k)-1 -: DATA_WIDTH].
- IDLE:
  - On tx accept: latch the frame; next cycle drive byte_out = byte 0 with a byte_valid_out pulse; go ARMED.
  - On cs_low (takes priority over a simultaneous tx_valid_in, which is not accepted): load an all-zero frame; pulse byte_valid_out with 0; idx = 0; go ACTIVE.
- ARMED: on cs_low, idx = 0, go ACTIVE. Further tx_valid_in is ignored (ready = 0).
- ACTIVE:
  - On byte_valid_in: rx_shift <= {rx_shift, byte_in}.
    - If idx == FRAME_WORDS-1: next cycle rx_data_out = assembled frame, rx_valid_out pulse; go WAIT_CS.
    - Else: idx+1; next cycle byte_out = byte idx+1 with a byte_valid_out pulse. This must land before the next DCLK falling edge, which the timing requirement guarantees.
  - On !cs_low before completion: frame_error_out pulse; discard rx_shift and the TX frame; rx_data_out unchanged; go IDLE.
  - Simultaneous final byte_valid_in and CS rise: the frame completes (rx_valid), no error.
- WAIT_CS:
  - byte_valid_in is ignored (overrun bytes dropped, no flag); no byte_valid_out.
  - On !cs_low go IDLE.
- rx_valid_out and frame_error_out are never high in the same cycle. Each fires at most once per CS-low period.
- Reset mid-frame returns to IDLE on the next edge and drops partial data. rx_data_out clears to 0.

Test Plan:
- FRAME_WORDS=4; load tx 0xDEADBEEF; master sends 0x01,0x02,0x03,0x04 under CS low -> CIPO bytes DE,AD,BE,EF; one rx_valid_out pulse with rx_data_out = 0x01020304; tx_ready_out returns to 1 after CS high.
- CS low with no TX frame loaded; master sends 0xA5A5A5A5 -> CIPO all zeros; rx_data_out = 0xA5A5A5A5; busy_out high throughout.
- Load 0x11223344; CS rises after 2 bytes -> one frame_error_out pulse; no rx_valid_out; state IDLE; next frame 0x55667788 transfers correctly.
- tx_valid_in asserted while CS low -> tx_ready_out = 0, frame not taken. Same cycle as IDLE CS fall -> not accepted; zero-fill used.
- Master clocks a 5th byte before CS rise -> exactly one rx_valid_out, 5th byte ignored, no error.
- rst_in asserted after byte 2 of a frame -> outputs at reset values next cycle; following full frame is received correctly.

Source files
------------

// File: rtl/spi_pe_frame_ctrl.sv
// Frame-level sequencer beside the byte-level SPI peripheral: feeds one wide TX
// frame out byte by byte and assembles received bytes into one wide RX frame.
module spi_pe_frame_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_WORDS = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [DATA_WIDTH*FRAME_WORDS-1:0] tx_data_in,
    input  logic                              tx_valid_in,
    output logic                              tx_ready_out,
    output logic [DATA_WIDTH-1:0]             byte_out,
    output logic                              byte_valid_out,
    input  logic [DATA_WIDTH-1:0]             byte_in,
    input  logic                              byte_valid_in,
    input  logic                              chip_sel_in,
    output logic [DATA_WIDTH*FRAME_WORDS-1:0] rx_data_out,
    output logic                              rx_valid_out,
    output logic                              frame_error_out,
    output logic                              busy_out
);

    localparam int FRAME_W  = DATA_WIDTH * FRAME_WORDS;
    localparam int RX_SH_W  = FRAME_W - DATA_WIDTH;
    localparam int IDX_W    = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_WAIT_CS = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_cs_meta;
    logic                 r_cs_sync;
    logic [FRAME_W-1:0]   r_tx_frame;
    logic [RX_SH_W-1:0]   r_rx_shift;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_WIDTH-1:0] r_byte;
    logic                 r_byte_valid;
    logic [FRAME_W-1:0]   r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_error;

    logic                 w_cs_low;
    logic                 w_last;
    logic [FRAME_W-1:0]   w_rx_next;

    assign w_cs_low  = ~r_cs_sync;
    assign w_last    = (r_idx == IDX_W'(FRAME_WORDS - 1));
    assign w_rx_next = {r_rx_shift, byte_in};

    assign tx_ready_out    = (r_state == ST_IDLE) && !w_cs_low && !rst_in;
    assign busy_out        = (r_state != ST_IDLE);
    assign byte_out        = r_byte;
    assign byte_valid_out  = r_byte_valid;
    assign rx_data_out     = r_rx_data;
    assign rx_valid_out    = r_rx_valid;
    assign frame_error_out = r_frame_error;

    // Two-flop synchroniser for the asynchronous chip select; idles deasserted (high).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
        end else begin
            r_cs_meta <= chip_sel_in;
            r_cs_sync <= r_cs_meta;
        end
    end

    // Frame sequencer. The TX frame register is shifted left after each byte so
    // the next byte to send always sits in the top DATA_WIDTH bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_tx_frame    <= '0;
            r_rx_shift    <= '0;
            r_idx         <= '0;
            r_byte        <= '0;
            r_byte_valid  <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_low) begin
                        r_tx_frame   <= '0;
                        r_rx_shift   <= '0;
                        r_byte       <= '0;
                        r_byte_valid <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= ST_ACTIVE;
                    end else if (tx_valid_in) begin
                        r_tx_frame   <= tx_data_in << DATA_WIDTH;
                        r_byte       <= tx_data_in[FRAME_W-1 -: DATA_WIDTH];
                        r_byte_valid <= 1'b1;
                        r_state      <= ST_ARMED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (w_cs_low) begin
                        r_idx      <= '0;
                        r_rx_shift <= '0;
                        r_state    <= ST_ACTIVE;
                    end else begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ACTIVE: begin
                    // A byte completing together with CS rising still counts.
                    if (byte_valid_in) begin
                        r_rx_shift <= w_rx_next[RX_SH_W-1:0];
                        if (w_last) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= ST_WAIT_CS;
                        end else begin
                            r_idx        <= r_idx + IDX_W'(1);
                            r_byte       <= r_tx_frame[FRAME_W-1 -: DATA_WIDTH];
                            r_tx_frame   <= r_tx_frame << DATA_WIDTH;
                            r_byte_valid <= 1'b1;
                            r_state      <= ST_ACTIVE;
                        end
                    end else if (!w_cs_low) begin
                        r_frame_error <= 1'b1;
                        r_rx_shift    <= '0;
                        r_tx_frame    <= '0;
                        r_idx         <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_WAIT_CS: begin
                    if (!w_cs_low) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_CS;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pe_frame_ctrl.sv
// Directed bench for spi_pe_frame_ctrl: drives peripheral byte completions and
// chip select directly and checks CIPO bytes, RX frames and status pulses.
module tb_spi_pe_frame_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] tx_data_in;
    logic        tx_valid_in;
    logic        tx_ready_out;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        chip_sel_in;
    logic [31:0] rx_data_out;
    logic        rx_valid_out;
    logic        frame_error_out;
    logic        busy_out;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int rx_base;
    int err_base;
    logic [7:0] cap[$];

    spi_pe_frame_ctrl #(.DATA_WIDTH(8), .FRAME_WORDS(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tx_data_in      (tx_data_in),
        .tx_valid_in     (tx_valid_in),
        .tx_ready_out    (tx_ready_out),
        .byte_out        (byte_out),
        .byte_valid_out  (byte_valid_out),
        .byte_in         (byte_in),
        .byte_valid_in   (byte_valid_in),
        .chip_sel_in     (chip_sel_in),
        .rx_data_out     (rx_data_out),
        .rx_valid_out    (rx_valid_out),
        .frame_error_out (frame_error_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (byte_valid_out) cap.push_back(byte_out);
        if (rx_valid_out) rx_cnt++;
        if (frame_error_out) err_cnt++;
        if (rx_valid_out && frame_error_out) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        step(1);
        byte_valid_in = 1'b0;
        step(3);
    endtask

    task automatic load_frame(input logic [31:0] f);
        tx_data_in  = f;
        tx_valid_in = 1'b1;
        step(1);
        tx_valid_in = 1'b0;
        step(1);
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] w, input int n);
        chk({tag, "_count"}, 32'(cap.size()), 32'(n));
        for (int i = 0; i < n && i < cap.size(); i++)
            chk({tag, "_byte"}, {24'h0, cap[i]}, {24'h0, w[8*(3-i) +: 8]});
        cap.delete();
    endtask

    initial begin
        rst_in = 1'b1; chip_sel_in = 1'b1; tx_valid_in = 1'b0;
        tx_data_in = 32'h0; byte_in = 8'h00; byte_valid_in = 1'b0;

        // Reset state
        step(3);
        @(negedge clk_in);
        chk("rst_ready", {31'h0, tx_ready_out}, 32'h0);
        chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
        chk("rst_rx_data", rx_data_out, 32'h0);
        chk("rst_busy", {31'h0, busy_out}, 32'h0);
        chk("rst_pulses", {29'h0, byte_valid_out, rx_valid_out, frame_error_out}, 32'h0);
        rst_in = 1'b0;
        step(3);
        @(negedge clk_in);
        chk("idle_ready", {31'h0, tx_ready_out}, 32'h1);
        cap.delete();

        // Full frame with a loaded TX word
        step(1);
        rx_base = rx_cnt; err_base = err_cnt;
        load_frame(32'hDEADBEEF);
        @(negedge clk_in);
        chk("armed_busy", {31'h0, busy_out}, 32'h1);
        chk("armed_ready", {31'h0, tx_ready_out}, 32'h0);
        step(1);
        chip_sel_in = 1'b0;
        step(4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check_bytes("t1_cipo", 32'hDEADBEEF, 4);
        chk("t1_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
        chk("t1_rx_data", rx_data_out, 32'h01020304);
        chk("t1_err", 32'(err_cnt - err_base), 32'd0);
        chip_sel_in = 1'b1;
        step(4);
        @(negedge clk_in);
        chk("t1_ready_back", {31'h0, tx_ready_out}, 32'h1);
        chk("t1_busy_low", {31'h0, busy_out}, 32'h0);

        // CS low with nothing loaded: zero fill
        step(1);
        rx_base = rx_cnt;
        chip_sel_in = 1'b0;
        step(4);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA5);
            chk("t2_busy", {31'h0, busy_out}, 32'h1);
        end
        check_bytes("t2_cipo", 32'h00000000, 4);
        chk("t2_rx_data", rx_data_out, 32'hA5A5A5A5);
        chk("t2_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
        tx_data_in = 32'hCAFEF00D; tx_valid_in = 1'b1;
        @(negedge clk_in);
        chk("t2_ready_cs_low", {31'h0, tx_ready_out}, 32'h0);
        step(1);
        tx_valid_in = 1'b0;
        chip_sel_in = 1'b1;
        step(4);
        @(negedge clk_in);
        chk("t2_not_taken", {31'h0, busy_out}, 32'h0);

        // Truncated frame, then a clean one
        step(1);
        rx_base = rx_cnt; err_base = err_cnt;
        load_frame(32'h11223344);
        chip_sel_in = 1'b0;
        step(4);
        send_byte(8'hAA); send_byte(8'hBB);
        chip_sel_in = 1'b1;
        step(5);
        @(negedge clk_in);
        chk("t3_err_cnt", 32'(err_cnt - err_base), 32'd1);
        chk("t3_no_rx", 32'(rx_cnt - rx_base), 32'd0);
        chk("t3_idle", {31'h0, busy_out}, 32'h0);
        chk("t3_rx_kept", rx_data_out, 32'hA5A5A5A5);
        check_bytes("t3_cipo", 32'h11223300, 3);
        step(1);
        load_frame(32'h55667788);
        chip_sel_in = 1'b0;
        step(4);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        check_bytes("t3b_cipo", 32'h55667788, 4);
        chk("t3b_rx_data", rx_data_out, 32'h10203040);
        chk("t3b_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
        chip_sel_in = 1'b1;
        step(4);

        // tx_valid in the cycle IDLE first sees CS low, plus a 5th overrun byte
        rx_base = rx_cnt; err_base = err_cnt;
        chip_sel_in = 1'b0;
        step(2);
        tx_data_in = 32'hCAFEF00D; tx_valid_in = 1'b1;
        @(negedge clk_in);
        chk("t4_ready_cs_fall", {31'h0, tx_ready_out}, 32'h0);
        step(1);
        tx_valid_in = 1'b0;
        step(2);
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_byte(8'h64);
        send_byte(8'h65);
        check_bytes("t4_cipo", 32'h00000000, 4);
        chk("t4_rx_data", rx_data_out, 32'h61626364);
        chk("t4_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
        chk("t4_err", 32'(err_cnt - err_base), 32'd0);
        chip_sel_in = 1'b1;
        step(4);
        @(negedge clk_in);
        chk("t4_ready_back", {31'h0, tx_ready_out}, 32'h1);

        // Reset in the middle of a frame
        step(1);
        err_base = err_cnt;
        load_frame(32'h0BADF00D);
        chip_sel_in = 1'b0;
        step(4);
        send_byte(8'hC1); send_byte(8'hC2);
        rst_in = 1'b1; chip_sel_in = 1'b1;
        step(1);
        @(negedge clk_in);
        chk("t5_byte_out", {24'h0, byte_out}, 32'h0);
        chk("t5_rx_data", rx_data_out, 32'h0);
        chk("t5_busy", {31'h0, busy_out}, 32'h0);
        chk("t5_ready_rst", {31'h0, tx_ready_out}, 32'h0);
        step(1);
        rst_in = 1'b0;
        step(4);
        cap.delete();
        rx_base = rx_cnt;
        load_frame(32'h12345678);
        chip_sel_in = 1'b0;
        step(4);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        check_bytes("t5_cipo", 32'h12345678, 4);
        chk("t5_rx_after", rx_data_out, 32'h9ABCDEF0);
        chk("t5_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
        chk("t5_no_err", 32'(err_cnt - err_base), 32'd0);
        chip_sel_in = 1'b1;
        step(4);

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
